// File: rtl/affect_channel_bank.sv
// Bank of NUM_CH saturating affect counters with tick-gated inc/dec, direct load,
// periodic decay toward per-channel baselines and a hysteretic 2-bit level per channel.
module affect_channel_bank #(
  parameter int NUM_CH       = 3,
  parameter int W            = 7,
  parameter int STEP         = 1,
  parameter int DECAY_PERIOD = 16,
  parameter int HYST         = 4,
  parameter logic [NUM_CH*W-1:0] RESET_VALS = {7'd64, 7'd0, 7'd96},
  localparam int LCW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tick,
  input  logic [NUM_CH-1:0]     inc,
  input  logic [NUM_CH-1:0]     dec,
  input  logic                  decay_en,
  input  logic                  load,
  input  logic [LCW-1:0]        load_ch,
  input  logic [W-1:0]          load_val,
  output logic [NUM_CH*W-1:0]   value,
  output logic [NUM_CH*2-1:0]   level,
  output logic [NUM_CH-1:0]     changed
);

  localparam int DW = (DECAY_PERIOD > 1) ? $clog2(DECAY_PERIOD) : 1;
  localparam logic [W-1:0]  MAXV     = {W{1'b1}};
  localparam logic [W-1:0]  B1       = W'(1 << (W - 2));
  localparam logic [W-1:0]  B2       = W'(2 << (W - 2));
  localparam logic [W-1:0]  B3       = W'(3 << (W - 2));
  localparam logic [DW-1:0] DIV_LAST = DW'(DECAY_PERIOD - 1);

  function automatic logic [1:0] raw_class(input logic [W-1:0] v);
    raw_class = 2'(v >= B1) + 2'(v >= B2) + 2'(v >= B3);
  endfunction

  function automatic logic [W:0] boundary(input logic [1:0] lvl);
    case (lvl)
      2'd1:    boundary = {1'b0, B1};
      2'd2:    boundary = {1'b0, B2};
      2'd3:    boundary = {1'b0, B3};
      default: boundary = '0;
    endcase
  endfunction

  // Addition is widened by one bit so the clamp sees the carry instead of a wrap.
  function automatic logic [W-1:0] sat_add(input logic [W-1:0] v, input logic [W:0] amt);
    logic [W:0] s;
    s = {1'b0, v} + amt;
    sat_add = (s > {1'b0, MAXV}) ? MAXV : s[W-1:0];
  endfunction

  function automatic logic [W-1:0] sat_sub(input logic [W-1:0] v, input logic [W-1:0] amt);
    sat_sub = (v < amt) ? '0 : v - amt;
  endfunction

  logic [W-1:0]      val_q [NUM_CH];
  logic [W-1:0]      val_d [NUM_CH];
  logic [1:0]        lvl_q [NUM_CH];
  logic [1:0]        lvl_d [NUM_CH];
  logic [NUM_CH-1:0] chg_q;
  logic [DW-1:0]     div_q;
  logic [DW-1:0]     div_d;
  logic              strobe;

  always_comb begin
    strobe = tick && (div_q == DIV_LAST);
    div_d  = div_q;
    if (tick) div_d = strobe ? '0 : div_q + DW'(1);
  end

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      // NOTE: every output of a combinational block gets a default first so no path infers a latch.
      val_d[i] = val_q[i];
      lvl_d[i] = lvl_q[i];

      if (load && (load_ch == LCW'(i))) begin
        val_d[i] = load_val;
      end else if (tick && inc[i] && dec[i]) begin
        val_d[i] = val_q[i];
      end else if (tick && inc[i]) begin
        val_d[i] = sat_add(val_q[i], (W+1)'(STEP));
      end else if (tick && dec[i]) begin
        val_d[i] = sat_sub(val_q[i], W'(STEP));
      end else if (strobe && decay_en) begin
        if (val_q[i] < RESET_VALS[i*W +: W])      val_d[i] = val_q[i] + W'(1);
        else if (val_q[i] > RESET_VALS[i*W +: W]) val_d[i] = val_q[i] - W'(1);
      end

      // Downward moves need the value HYST below the boundary; the landing class
      // is taken from value+HYST so a deep drop settles one margin above its raw class.
      if (raw_class(val_q[i]) > lvl_q[i]) begin
        lvl_d[i] = raw_class(val_q[i]);
      end else if ((raw_class(val_q[i]) < lvl_q[i]) &&
                   (({1'b0, val_q[i]} + (W+1)'(HYST)) < boundary(lvl_q[i]))) begin
        lvl_d[i] = raw_class(sat_add(val_q[i], (W+1)'(HYST)));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the per-channel arrays are plain flops, not RAM, so resetting them is legal and intended.
      for (int i = 0; i < NUM_CH; i++) begin
        val_q[i] <= RESET_VALS[i*W +: W];
        lvl_q[i] <= raw_class(RESET_VALS[i*W +: W]);
      end
      chg_q <= '0;
      div_q <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      for (int i = 0; i < NUM_CH; i++) begin
        val_q[i] <= val_d[i];
        lvl_q[i] <= lvl_d[i];
        chg_q[i] <= (lvl_d[i] != lvl_q[i]);
      end
      div_q <= div_d;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_out
    assign value[g*W +: W] = val_q[g];
    assign level[g*2 +: 2] = lvl_q[g];
  end
  assign changed = chg_q;

endmodule

// File: tb/tb_affect_channel_bank.sv
// Self-checking bench for affect_channel_bank: vector table, hand-written corner
// sequences and randomized traffic against an arithmetic reference model.
module tb_affect_channel_bank;

  localparam int NUM_CH = 3;
  localparam int W      = 7;
  localparam int STEP   = 1;
  localparam int DP     = 16;
  localparam int HYST   = 4;
  localparam int MAXV   = (1 << W) - 1;
  localparam int QTR    = (1 << W) / 4;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic                tick = 1'b0;
  logic [NUM_CH-1:0]   inc = '0;
  logic [NUM_CH-1:0]   dec = '0;
  logic                decay_en = 1'b0;
  logic                load = 1'b0;
  logic [1:0]          load_ch = '0;
  logic [W-1:0]        load_val = '0;
  logic [NUM_CH*W-1:0] value;
  logic [NUM_CH*2-1:0] level;
  logic [NUM_CH-1:0]   changed;

  int n_cmp  = 0;
  int n_fail = 0;

  affect_channel_bank #(
    .NUM_CH(NUM_CH), .W(W), .STEP(STEP), .DECAY_PERIOD(DP), .HYST(HYST),
    .RESET_VALS({7'd64, 7'd0, 7'd96})
  ) dut (
    .clk(clk), .rst(rst), .tick(tick), .inc(inc), .dec(dec),
    .decay_en(decay_en), .load(load), .load_ch(load_ch), .load_val(load_val),
    .value(value), .level(level), .changed(changed)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int         m_val [NUM_CH];
  int         m_lvl [NUM_CH];
  int         m_div;
  logic [2:0] m_chg;

  function automatic int base_of(int i);
    case (i)
      0:       return 96;
      1:       return 0;
      default: return 64;
    endcase
  endfunction

  function automatic int raw_cls(int v);
    int c;
    c = v / QTR;
    return (c > 3) ? 3 : c;
  endfunction

  task automatic model_step(input logic r, input logic t, input logic [2:0] mi,
                            input logic [2:0] md, input logic den, input logic ld,
                            input logic [1:0] lc, input int lv);
    bit strobe;
    if (r) begin
      for (int i = 0; i < NUM_CH; i++) begin
        m_val[i] = base_of(i);
        m_lvl[i] = raw_cls(base_of(i));
      end
      m_chg = '0;
      m_div = 0;
      return;
    end
    strobe = t && (m_div == DP - 1);
    if (t) m_div = (m_div + 1) % DP;
    for (int i = 0; i < NUM_CH; i++) begin
      int c;
      int nl;
      int v;
      v  = m_val[i];
      c  = raw_cls(v);
      nl = m_lvl[i];
      if (c > m_lvl[i]) nl = c;
      else if (c < m_lvl[i] && v < m_lvl[i] * QTR - HYST)
        nl = raw_cls((v + HYST > MAXV) ? MAXV : v + HYST);
      m_chg[i] = (nl != m_lvl[i]);
      m_lvl[i] = nl;
      if (ld && lc == i)          m_val[i] = lv;
      else if (t && mi[i] && md[i]) m_val[i] = v;
      else if (t && mi[i])        m_val[i] = (v + STEP > MAXV) ? MAXV : v + STEP;
      else if (t && md[i])        m_val[i] = (v - STEP < 0) ? 0 : v - STEP;
      else if (strobe && den) begin
        if (v < base_of(i))      m_val[i] = v + 1;
        else if (v > base_of(i)) m_val[i] = v - 1;
      end
    end
  endtask

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int chv(int i);
    return int'(value[i*W +: W]);
  endfunction

  function automatic int chl(int i);
    return int'(level[i*2 +: 2]);
  endfunction

  task automatic cycle(input logic r, input logic t, input logic [2:0] i_inc,
                       input logic [2:0] i_dec, input logic den, input logic ld,
                       input logic [1:0] lc, input logic [6:0] lv);
    logic [NUM_CH*W-1:0] ev;
    logic [NUM_CH*2-1:0] el;
    rst = r; tick = t; inc = i_inc; dec = i_dec;
    decay_en = den; load = ld; load_ch = lc; load_val = lv;
    model_step(r, t, i_inc, i_dec, den, ld, lc, int'(lv));
    @(posedge clk);
    #1;
    for (int i = 0; i < NUM_CH; i++) begin
      ev[i*W +: W] = W'(m_val[i]);
      el[i*2 +: 2] = 2'(m_lvl[i]);
    end
    check("model_value", 64'(value), 64'(ev));
    check("model_level", 64'(level), 64'(el));
    check("model_changed", 64'(changed), 64'(m_chg));
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle(0, 0, 3'b000, 3'b000, 0, 0, 2'd0, 7'd0);
  endtask

  task automatic ticks(input int n, input logic [2:0] i_inc, input logic [2:0] i_dec,
                       input logic den);
    for (int k = 0; k < n; k++) cycle(0, 1, i_inc, i_dec, den, 0, 2'd0, 7'd0);
  endtask

  task automatic do_reset();
    cycle(1, 0, 3'b000, 3'b000, 0, 0, 2'd0, 7'd0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic       t;
    logic [2:0] i_inc;
    logic [2:0] i_dec;
    logic       ld;
    logic [1:0] lc;
    logic [6:0] lv;
    int         e0;
    int         e1;
    int         e2;
  } vec_t;

  vec_t vecs [12];

  initial begin
    vecs[0]  = '{1'b1, 3'b000, 3'b010, 1'b0, 2'd0, 7'd0,   96,  0,  64};
    vecs[1]  = '{1'b1, 3'b001, 3'b000, 1'b0, 2'd0, 7'd0,   97,  0,  64};
    vecs[2]  = '{1'b1, 3'b001, 3'b001, 1'b0, 2'd0, 7'd0,   97,  0,  64};
    vecs[3]  = '{1'b0, 3'b111, 3'b000, 1'b0, 2'd0, 7'd0,   97,  0,  64};
    vecs[4]  = '{1'b0, 3'b000, 3'b000, 1'b1, 2'd1, 7'd10,  97, 10,  64};
    vecs[5]  = '{1'b1, 3'b000, 3'b000, 1'b1, 2'd3, 7'd55,  97, 10,  64};
    vecs[6]  = '{1'b1, 3'b000, 3'b100, 1'b0, 2'd0, 7'd0,   97, 10,  63};
    vecs[7]  = '{1'b1, 3'b001, 3'b000, 1'b1, 2'd0, 7'd5,    5, 10,  63};
    vecs[8]  = '{1'b1, 3'b110, 3'b000, 1'b0, 2'd0, 7'd0,    5, 11,  64};
    vecs[9]  = '{1'b1, 3'b100, 3'b000, 1'b1, 2'd2, 7'd127,  5, 11, 127};
    vecs[10] = '{1'b1, 3'b100, 3'b000, 1'b0, 2'd0, 7'd0,    5, 11, 127};
    vecs[11] = '{1'b1, 3'b010, 3'b001, 1'b0, 2'd0, 7'd0,    4, 12, 127};

    // Reset state
    do_reset();
    check("reset_v0", chv(0), 96);
    check("reset_v1", chv(1), 0);
    check("reset_v2", chv(2), 64);
    check("reset_l0", chl(0), 3);
    check("reset_l1", chl(1), 0);
    check("reset_l2", chl(2), 2);
    check("reset_changed", 64'(changed), 0);

    // Table-driven single-cycle vectors
    for (int n = 0; n < 12; n++) begin
      cycle(0, vecs[n].t, vecs[n].i_inc, vecs[n].i_dec, 0, vecs[n].ld, vecs[n].lc, vecs[n].lv);
      check($sformatf("vec%0d_v0", n), chv(0), vecs[n].e0);
      check($sformatf("vec%0d_v1", n), chv(1), vecs[n].e1);
      check($sformatf("vec%0d_v2", n), chv(2), vecs[n].e2);
    end

    // Mid-count reset
    do_reset();
    ticks(4, 3'b001, 3'b000, 0);
    check("midreset_pre_v0", chv(0), 100);
    cycle(1, 1, 3'b001, 3'b000, 0, 1, 2'd0, 7'd7);
    check("midreset_v0", chv(0), 96);
    check("midreset_l0", chl(0), 3);
    check("midreset_changed", 64'(changed), 0);

    // Saturation
    do_reset();
    ticks(5, 3'b000, 3'b010, 0);
    check("sat_low_v1", chv(1), 0);
    ticks(30, 3'b001, 3'b000, 0);
    check("sat_126_v0", chv(0), 126);
    ticks(10, 3'b001, 3'b000, 0);
    check("sat_high_v0", chv(0), 127);
    ticks(1, 3'b001, 3'b001, 0);
    check("sat_incdec_v0", chv(0), 127);

    // Hysteresis on ch2
    do_reset();
    ticks(1, 3'b000, 3'b100, 0);
    check("hyst63_v2", chv(2), 63);
    idle(1);
    check("hyst63_l2", chl(2), 2);
    check("hyst63_chg", 64'(changed), 0);
    ticks(3, 3'b000, 3'b100, 0);
    idle(1);
    check("hyst60_v2", chv(2), 60);
    check("hyst60_l2", chl(2), 2);
    ticks(1, 3'b000, 3'b100, 0);
    check("hyst59_v2", chv(2), 59);
    check("hyst59_l2_pre", chl(2), 2);
    idle(1);
    check("hyst59_l2", chl(2), 1);
    check("hyst59_chg", 64'(changed), 64'(3'b100));
    idle(1);
    check("hyst59_chg_end", 64'(changed), 0);
    ticks(4, 3'b100, 3'b000, 0);
    idle(1);
    check("hystup63_v2", chv(2), 63);
    check("hystup63_l2", chl(2), 1);
    check("hystup63_chg", 64'(changed), 0);
    ticks(1, 3'b100, 3'b000, 0);
    idle(1);
    check("hystup64_l2", chl(2), 2);
    check("hystup64_chg", 64'(changed), 64'(3'b100));
    idle(1);
    check("hystup64_chg_end", 64'(changed), 0);

    // Decay toward baseline
    do_reset();
    cycle(0, 0, 3'b000, 3'b000, 1, 1, 2'd1, 7'd10);
    check("decay_load_v1", chv(1), 10);
    for (int k = 1; k <= 47; k++) begin
      ticks(1, 3'b000, 3'b000, 1);
      if (k == 15) check("decay_t15_v1", chv(1), 10);
      if (k == 16) check("decay_t16_v1", chv(1), 9);
      if (k == 16) check("decay_t16_v0", chv(0), 96);
      if (k == 16) check("decay_t16_v2", chv(2), 64);
      if (k == 32) check("decay_t32_v1", chv(1), 8);
      if (k == 32) check("decay_t32_v0", chv(0), 96);
    end
    ticks(1, 3'b010, 3'b000, 1);
    check("decay_inc_strobe_v1", chv(1), 9);

    // Load precedence
    do_reset();
    cycle(0, 1, 3'b001, 3'b000, 0, 1, 2'd0, 7'd5);
    check("load_v0", chv(0), 5);
    check("load_l0_pre", chl(0), 3);
    idle(1);
    check("load_l0", chl(0), 0);
    check("load_chg", 64'(changed), 64'(3'b001));
    idle(1);
    check("load_chg_end", 64'(changed), 0);
    cycle(0, 0, 3'b000, 3'b000, 0, 1, 2'd3, 7'd55);
    check("load_ch3_v0", chv(0), 5);
    check("load_ch3_v1", chv(1), 0);
    check("load_ch3_v2", chv(2), 64);

    // Randomized traffic against the model
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      cycle(($urandom_range(0, 299) == 0),
            ($urandom_range(0, 3) != 0),
            3'($urandom) & 3'($urandom),
            3'($urandom) & 3'($urandom),
            1'($urandom_range(0, 1)),
            ($urandom_range(0, 9) == 0),
            2'($urandom),
            7'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
